// File: rtl/ros2_eth_pkg.sv
// ---------------------------------------------------------------------------
// ros2_eth_pkg
// Shared constants and types for the ROS2-over-Ethernet TX path.
//   IP_HDR_SIZE            : minimum IPv4 header length in bytes; also the
//                            minimum number of bytes the TX adapter reads.
//   IP_HDR_OFFSET_TOT_LEN  : byte offset of the 16-bit Total Length field.
//   arb_state_e            : TX arbiter FSM encoding (IDLE / PASS).
//   ip_eff_len()           : Total Length clamped to at least one header.
// ---------------------------------------------------------------------------
package ros2_eth_pkg;

  localparam int IP_HDR_SIZE           = 20;
  localparam int IP_HDR_OFFSET_TOT_LEN = 2;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_e;

  // A Total Length below one header is treated as a header-only packet so
  // the arbiter and the adapter always agree on at least 20 bytes.
  function automatic logic [15:0] ip_eff_len(input logic [15:0] tot_len);
    if (tot_len < 16'(IP_HDR_SIZE)) begin
      return 16'(IP_HDR_SIZE);
    end
    return tot_len;
  endfunction

endpackage

// File: rtl/ros2_eth_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// ros2_eth_tx_arbiter_if
// Byte-stream bundle between N_SRC packet-builder FIFOs, the TX arbiter and
// the TX adapter's din port.
//   i_src_data     : byte from source k at bits [8k+7:8k]
//   i_src_empty_n  : source k has a byte available
//   o_src_rd_en    : pop strobe to source k
//   o_dout_data    : byte to the TX adapter
//   o_dout_empty_n : byte valid to the TX adapter
//   i_dout_rd_en   : pop strobe from the TX adapter
//
// Handshake: every link is FIFO-style. empty_n is the valid, rd_en is the
// ready/pop. A byte moves exactly in a cycle where both are high at the
// rising clock edge; rd_en while empty_n is low has no effect. A producer
// must hold its byte stable until it is popped.
//
// Modports: master = arbiter side, slave = sources + adapter side.
// ---------------------------------------------------------------------------
interface ros2_eth_tx_arbiter_if #(
  parameter int N_SRC = 4
) ();

  logic [8*N_SRC-1:0] i_src_data;
  logic [N_SRC-1:0]   i_src_empty_n;
  logic [N_SRC-1:0]   o_src_rd_en;
  logic [7:0]         o_dout_data;
  logic               o_dout_empty_n;
  logic               i_dout_rd_en;

  modport master (
    input  i_src_data,
    input  i_src_empty_n,
    input  i_dout_rd_en,
    output o_src_rd_en,
    output o_dout_data,
    output o_dout_empty_n
  );

  modport slave (
    output i_src_data,
    output i_src_empty_n,
    output i_dout_rd_en,
    input  o_src_rd_en,
    input  o_dout_data,
    input  o_dout_empty_n
  );

endinterface

// File: rtl/rr_arbiter_sel.sv
// ---------------------------------------------------------------------------
// rr_arbiter_sel
// Combinational round-robin first-set finder. Returns the first asserted
// request at or after i_ptr, searching upward with wrap modulo N.
//   i_req : request vector
//   i_ptr : search start index (must be < N)
//   o_gnt : one-hot winner (zero when no request)
//   o_idx : binary index of the winner (zero when no request)
//   o_any : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter_sel #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[cand]) begin
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ros2_eth_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ros2_eth_tx_arbiter
// Round-robin arbiter sharing the TX adapter's IPv4 byte stream among N_SRC
// packet sources. One complete packet per grant; the packet length is taken
// from the IPv4 Total Length field as it streams past.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_enable       : low aborts any grant (same enable as the TX adapter)
//   bus            : source/adapter byte streams (master modport)
//   o_grant        : one-hot current owner, zero when idle
//   o_busy         : a packet transfer is in progress
//   o_pkt_count    : completed packets, wraps modulo 2^16
//   o_dbg_state    : FSM state
//   o_dbg_rr_ptr   : round-robin search start for the next arbitration
// ---------------------------------------------------------------------------
module ros2_eth_tx_arbiter
  import ros2_eth_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  ros2_eth_tx_arbiter_if.master      bus,
  output logic [N_SRC-1:0]           o_grant,
  output logic                       o_busy,
  output logic [15:0]                o_pkt_count,
  output arb_state_e                 o_dbg_state,
  output logic [$clog2(N_SRC)-1:0]   o_dbg_rr_ptr
);

  localparam int          IDX_W      = $clog2(N_SRC);
  localparam logic [15:0] HDR_LEN    = 16'(IP_HDR_SIZE);
  localparam logic [15:0] LAST_HDR   = 16'(IP_HDR_SIZE - 1);
  localparam logic [15:0] LEN_HI_POS = 16'(IP_HDR_OFFSET_TOT_LEN);
  localparam logic [15:0] LEN_LO_POS = 16'(IP_HDR_OFFSET_TOT_LEN + 1);

  arb_state_e        state_q,     state_d;
  logic [N_SRC-1:0]  grant_q,     grant_d;
  logic [IDX_W-1:0]  gidx_q,      gidx_d;
  logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [15:0]       byte_cnt_q,  byte_cnt_d;
  logic [15:0]       len_q,       len_d;
  logic [15:0]       pkt_count_q, pkt_count_d;

  logic [N_SRC-1:0]  sel_gnt;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_any;

  logic [7:0]        src_byte;
  logic              src_avail;
  logic              xfer;
  logic              pkt_end;
  logic [15:0]       eff_len;

  rr_arbiter_sel #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_sel (
    .i_req (bus.i_src_empty_n),
    .i_ptr (rr_ptr_q),
    .o_gnt (sel_gnt),
    .o_idx (sel_idx),
    .o_any (sel_any)
  );

  // Data mux driven by the registered one-hot grant. The grant is zero in
  // IDLE, so every output below is zero there without extra gating.
  always_comb begin
    src_byte  = '0;
    src_avail = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q[k]) begin
        src_byte  = bus.i_src_data[8*k +: 8];
        src_avail = bus.i_src_empty_n[k];
      end
    end
  end

  assign bus.o_dout_data    = src_byte;
  assign bus.o_dout_empty_n = src_avail;
  assign bus.o_src_rd_en    = grant_q & {N_SRC{src_avail & bus.i_dout_rd_en}};

  assign xfer    = (state_q == ARB_PASS) && src_avail && bus.i_dout_rd_en;
  assign eff_len = ip_eff_len(len_q);
  // 17-bit compare so byte_cnt = 65535 cannot wrap into a false match.
  assign pkt_end = xfer && (byte_cnt_q >= LAST_HDR) &&
                   (({1'b0, byte_cnt_q} + 17'd1) == {1'b0, eff_len});

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    pkt_count_d = pkt_count_q;

    case (state_q)
      ARB_IDLE: begin
        if (i_enable && sel_any) begin
          state_d    = ARB_PASS;
          grant_d    = sel_gnt;
          gidx_d     = sel_idx;
          byte_cnt_d = '0;
          len_d      = HDR_LEN;
        end
      end
      ARB_PASS: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == LEN_HI_POS) len_d[15:8] = src_byte;
          if (byte_cnt_q == LEN_LO_POS) len_d[7:0]  = src_byte;
          if (pkt_end) begin
            state_d     = ARB_IDLE;
            grant_d     = '0;
            rr_ptr_d    = (gidx_q == IDX_W'(N_SRC - 1)) ? '0 : gidx_q + IDX_W'(1);
            pkt_count_d = pkt_count_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase

    // Disable wins over everything, but a byte that moved this cycle still
    // completes its packet bookkeeping above.
    if (!i_enable) begin
      state_d = ARB_IDLE;
      grant_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      len_q       <= HDR_LEN;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_busy       = (state_q == ARB_PASS);
  assign o_pkt_count  = pkt_count_q;
  assign o_dbg_state  = state_q;
  assign o_dbg_rr_ptr = rr_ptr_q;

endmodule

// File: doc/ros2_eth_tx_arbiter.md
# ros2_eth_tx_arbiter

Shares the single IP-packet byte stream feeding the Ethernet TX adapter among `N_SRC` packet sources (e.g. SPDP, SEDP and user-topic packet builders). Each source presents complete IPv4 packets, header first, on a FIFO-style read interface. The arbiter grants one source at a time in round-robin order and passes its bytes through unchanged. It holds the grant for exactly one packet, whose length is parsed from the IPv4 Total Length field. It sits between the packet-builder FIFOs and the TX adapter's `din` port.

## Interface
- `N_SRC`, default 4: number of requesters, 2..8.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_enable`  in  1  same enable as the TX adapter. Low aborts any grant.
- `i_src_data`  in  8*N_SRC  byte from source k, at bits [8k+7:8k].
- `i_src_empty_n`  in  N_SRC  source k has a byte available.
- `o_src_rd_en`  out  N_SRC  pop strobe to source k.
- `o_dout_data`  out  8  byte to the TX adapter.
- `o_dout_empty_n`  out  1  byte valid to the TX adapter.
- `i_dout_rd_en`  in  1  pop strobe from the TX adapter.
- `o_grant`  out  N_SRC  one-hot current owner; zero when idle.
- `o_busy`  out  1  a packet transfer is in progress.
- `o_pkt_count`  out  16  completed packets, wrapping modulo 2^16.

## Operation
- A transfer occurs in a cycle where the arbiter is in PASS, the granted source has `i_src_empty_n` high, and `i_dout_rd_en` is high.
- State IDLE:
  - `o_grant`=0; `o_dout_empty_n`=0; all `o_src_rd_en`=0.
  - If `i_enable` is high and any `i_src_empty_n` bit is set, select the first requester at or after `rr_ptr`, searching upward with modulo wrap.
  - Latch that requester as the grant, clear `byte_cnt`, set `len`=20, and go to PASS.
- State PASS:
  - `o_dout_data` = granted source's data.
  - `o_dout_empty_n` = granted source's empty_n.
  - `o_src_rd_en[g]` = `i_dout_rd_en` & granted source's empty_n; all other bits are 0.
- Per transfer in PASS:
  - `byte_cnt` increments.
  - At `byte_cnt`==2, capture the byte into `len[15:8]`.
  - At `byte_cnt`==3, capture it into `len[7:0]`.
- Effective length `eff_len` = max(`len`, 20). A Total Length below 20 is treated as a header-only packet, matching the adapter's minimum read of 20 bytes.
- Packet end is the transfer with `byte_cnt` ≥ 19 and `byte_cnt`+1 == `eff_len`. On that transfer:
  - go to IDLE;
  - set `rr_ptr` = grant index + 1, modulo `N_SRC`;
  - increment `o_pkt_count`.
- The arbiter never re-arbitrates mid-packet. Source empty_n dropping during PASS stalls the transfer; the grant is held.
- Width rules:
  - `byte_cnt` and `len` are 16 bits.
  - The comparison uses the full 16 bits.
  - `len` up to 65535 is supported with no truncation.
- `i_enable` low in any state forces IDLE next cycle and clears the grant. `rr_ptr` and `o_pkt_count` are kept. A partially sent packet is abandoned and its remaining bytes stay in the source FIFO, which must be flushed by the owner. The adapter resets itself on the same condition.
- Reset values:
  - IDLE, `rr_ptr`=0, `byte_cnt`=0, `len`=20, `o_pkt_count`=0.
  - All outputs 0.

## Timing
- Arbitration takes 1 cycle: a request seen in IDLE at edge t produces the grant and PASS outputs after t.
- There is a one-cycle IDLE bubble between back-to-back packets, including repeat grants to the same source.
- The data path is combinational: `o_dout_*` and `o_src_rd_en` follow the mux with zero latency. The mux select is registered (the grant register), so no combinational path exists from request to grant.
- `i_dout_rd_en` asserted while `o_dout_empty_n` is low causes no pop and no count.
- A simultaneous packet-end and `i_enable` deassertion resolves as disable: state goes to IDLE, and `o_pkt_count` is still incremented because the transfer completed.

## Structure
- Shared package `ros2_eth_pkg` holds:
  - `IP_HDR_SIZE`=20 and `IP_HDR_OFFSET_TOT_LEN`=2, shared with the TX adapter;
  - state encodings `ARB_IDLE` and `ARB_PASS`.
- One sub-module, `rr_arbiter_sel`, is natural: a combinational round-robin first-set finder taking the request vector and `rr_ptr` and returning a one-hot grant plus index. It is reusable by the RX-side dispatcher.
- The FSM, counters and mux live in the top module. Expect about 200 lines of RTL.

## Test plan
- **Single source, header-only:** source 1 holds a packet with Total Length 0x0014; the sink has rd_en held high.
  - Exactly 20 bytes pop from source 1; grant 0b0010 lasts 20 transfer cycles.
  - Then IDLE; `o_pkt_count`=1; `rr_ptr`=2.
- **Round-robin fairness:** all 4 sources hold two packets each with Total Length 28.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each grant carries 28 bytes with one idle cycle between packets.
  - `o_pkt_count`=8.
- **Stalls:** source 2 sends a 60-byte packet while sink rd_en and source empty_n toggle pseudo-randomly.
  - Byte stream is identical to the source contents.
  - Grant never changes until the 60th transfer.
  - No pop occurs on a cycle where empty_n or rd_en is low.
- **Short length clamp:** Total Length 0x0005.
  - 20 bytes are transferred, then the packet ends.
  - The next source is granted afterwards.
- **Disable mid-packet:** `i_enable` is dropped at byte 30 of a 100-byte packet from source 0.
  - Next cycle: grant=0 and `o_dout_empty_n`=0.
  - `o_pkt_count` is unchanged; `rr_ptr` is unchanged.
  - After `i_enable` returns high, arbitration restarts.
- **Async reset mid-packet:** `i_rst_n` is pulsed low for a fraction of a cycle.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - `o_pkt_count`=0 and `rr_ptr`=0 after release.
